gcd_requester: RTL

Initiator side of the GCD engine's start/done handshake. Accepts operand pairs from an upstream valid/ready stream, issues each to a single GCD engine, waits for completion, and buffers results in a small in-order FIFO for a downstream valid/ready consumer. Sits between the system datapath and the GCD engine and owns all engine sequencing.

---
 rtl/gcd_req_pkg.sv | 26 ++
 rtl/gcd_req_fifo.sv | 78 +++++++
 rtl/gcd_requester.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/gcd_req_pkg.sv
// Shared types and constants for the GCD requester and its result FIFO.
package gcd_req_pkg;

  localparam int unsigned OP_W    = 32;
  localparam int unsigned ENTRY_W = 1 + 3 * OP_W;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] ERROR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_ISSUE = ISSUE,
    ST_WAIT  = WAIT,
    ST_ERROR = ERROR
  } state_e;

  typedef struct packed {
    logic            err;
    logic [OP_W-1:0] opa;
    logic [OP_W-1:0] opb;
    logic [OP_W-1:0] result;
  } gcd_entry_t;

endpackage

// File: rtl/gcd_req_fifo.sv
// In-order result FIFO with a registered head entry and registered count/full/empty.
// Push and pop may coincide at any occupancy, including full.
module gcd_req_fifo
  import gcd_req_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  gcd_entry_t                 wdata,
  input  logic                       pop,
  output gcd_entry_t                 head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  gcd_entry_t         head_q, head_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               do_push, do_pop;

  // Pointer/count update and next head selection.
  always_comb begin
    do_pop   = pop && !empty_q;
    do_push  = push && (!full_q || do_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    full_d   = (count_d == CNT_W'(DEPTH));
    empty_d  = (count_d == '0);
    head_d   = head_q;
    // The incoming entry lands at the head when everything ahead of it is gone.
    if (do_push && (wr_ptr_q == rd_ptr_d)) begin
      head_d = wdata;
    end else if (do_pop && !empty_d) begin
      head_d = gcd_entry_t'(mem_q[rd_ptr_d]);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= ENTRY_W'(wdata);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign head  = head_q;
  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/gcd_requester.sv
// Initiator for a single GCD engine: issues one job at a time and queues results in order.
// Optional WAIT watchdog is enabled by defining GCD_REQ_TIMEOUT_EN.
module gcd_requester
  import gcd_req_pkg::*;
#(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] in_opa,
  input  logic [OP_W-1:0] in_opb,
  output logic            eng_start,
  output logic [OP_W-1:0] eng_opa,
  output logic [OP_W-1:0] eng_opb,
  input  logic            eng_done,
  input  logic [OP_W-1:0] eng_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] out_opa,
  output logic [OP_W-1:0] out_opb,
  output logic [OP_W-1:0] out_result,
  output logic            out_err,
  output logic            busy,
  output logic            err_sticky
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  state_e          state_q, state_d;
  logic            eng_start_q, eng_start_d;
  logic [OP_W-1:0] eng_opa_q, eng_opa_d;
  logic [OP_W-1:0] eng_opb_q, eng_opb_d;
  logic            busy_q, busy_d;
  logic            err_sticky_q, err_sticky_d;
  logic            pend_q, pend_d;

  logic            push_c, push_err_c, pop_c, tmo_hit_c, fifo_room_c;
  gcd_entry_t      fifo_wdata, fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic            fifo_full, fifo_empty;

`ifdef GCD_REQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Counts consecutive WAIT cycles; cleared everywhere else.
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == ST_WAIT) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign tmo_hit_c = (state_q == ST_WAIT) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit_c = 1'b0;
`endif

  assign fifo_room_c = (fifo_count < CNT_W'(DEPTH));
  assign in_ready    = (state_q == ST_IDLE) && fifo_room_c;
  assign pop_c       = !fifo_empty && out_ready;

  // Job sequencing; engine done outside WAIT is deliberately ignored.
  always_comb begin
    state_d      = state_q;
    eng_start_d  = 1'b0;
    eng_opa_d    = eng_opa_q;
    eng_opb_d    = eng_opb_q;
    err_sticky_d = err_sticky_q;
    pend_d       = pend_q;
    push_c       = 1'b0;
    push_err_c   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          eng_opa_d   = in_opa;
          eng_opb_d   = in_opb;
          eng_start_d = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A done on the expiry cycle still counts as success.
        if (eng_done) begin
          push_c  = 1'b1;
          state_d = ST_IDLE;
        end else if (tmo_hit_c) begin
          err_sticky_d = 1'b1;
          state_d      = ST_ERROR;
          if (!fifo_full) begin
            push_c     = 1'b1;
            push_err_c = 1'b1;
          end else begin
            pend_d = 1'b1;
          end
        end
      end
      ST_ERROR: begin
        if (pend_q && !fifo_full) begin
          push_c     = 1'b1;
          push_err_c = 1'b1;
          pend_d     = 1'b0;
        end
      end
    endcase
    busy_d = (state_d == ST_ISSUE) || (state_d == ST_WAIT);

    fifo_wdata.err    = push_err_c;
    fifo_wdata.opa    = eng_opa_q;
    fifo_wdata.opb    = eng_opb_q;
    fifo_wdata.result = push_err_c ? '0 : eng_result;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      eng_start_q  <= 1'b0;
      eng_opa_q    <= '0;
      eng_opb_q    <= '0;
      busy_q       <= 1'b0;
      err_sticky_q <= 1'b0;
      pend_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      eng_start_q  <= eng_start_d;
      eng_opa_q    <= eng_opa_d;
      eng_opb_q    <= eng_opb_d;
      busy_q       <= busy_d;
      err_sticky_q <= err_sticky_d;
      pend_q       <= pend_d;
    end
  end

  gcd_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .wdata (fifo_wdata),
    .pop   (pop_c),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign eng_start  = eng_start_q;
  assign eng_opa    = eng_opa_q;
  assign eng_opb    = eng_opb_q;
  assign busy       = busy_q;
  assign err_sticky = err_sticky_q;
  assign out_valid  = !fifo_empty;
  assign out_opa    = fifo_head.opa;
  assign out_opb    = fifo_head.opb;
  assign out_result = fifo_head.result;
  assign out_err    = fifo_head.err;

endmodule
